// File: rtl/integrate_dump_if.sv
`default_nettype none
// ============================================================================
//  Module      : integrate_dump_if
//  Description : Sample-in / result-out handshake bundle for integrate_dump.
//                Upstream side:   s_valid, s_ready, s_data
//                Downstream side: m_valid, m_ready, m_data, m_ovf
//                The master modport is the environment driving samples and
//                accepting results; the slave modport is the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface integrate_dump_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 19
);
    logic                 s_valid;
    logic                 s_ready;
    logic [WIDTH_IN-1:0]  s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [WIDTH_ACC-1:0] m_data;
    logic                 m_ovf;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ovf
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ovf
    );
endinterface
`default_nettype wire

// File: rtl/integrate_dump.sv
`default_nettype none
// ============================================================================
//  Module      : integrate_dump
//  Description : Streaming integrate-and-dump accumulator. Sums a block of
//                len input samples (len==0 treated as 1) and emits one
//                WIDTH_ACC-bit result per block, one sample per cycle with
//                no bubble between blocks.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                clear  - synchronous abort of the current partial block
//                len    - samples per block, sampled on a block's first sample
//                bus    - integrate_dump_if.slave (s_* sample input,
//                         m_* result output incl. m_ovf)
//  Options     : INTDUMP_SAT_EN - when defined, the accumulator saturates on
//                overflow and m_ovf reports a sticky per-block overflow flag;
//                when undefined, the sum wraps and m_ovf is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module integrate_dump #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 19,
    parameter int LEN_WIDTH = 4,
    parameter int IS_SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [LEN_WIDTH-1:0] len,
    integrate_dump_if.slave      bus
);

    localparam logic [0:0]           c_st_idle  = 1'b0;
    localparam logic [0:0]           c_st_accum = 1'b1;
    localparam logic [LEN_WIDTH-1:0] c_len_one  = LEN_WIDTH'(1);

    generate
        if (WIDTH_ACC < WIDTH_IN) begin : g_width_check
            $error("integrate_dump: WIDTH_ACC must be >= WIDTH_IN");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] r_len_q;
    logic [WIDTH_ACC-1:0] r_acc;
    logic                 r_m_valid;
    logic [WIDTH_ACC-1:0] r_m_data;

    logic [LEN_WIDTH-1:0] w_len_eff;
    logic                 w_last;
    logic                 w_s_ready;
    logic                 w_accept;
    logic                 w_complete;
    logic [WIDTH_ACC-1:0] w_ext;
    logic [WIDTH_ACC-1:0] w_acc_next;

    assign w_len_eff = (len == '0) ? c_len_one : len;

    generate
        if (IS_SIGNED != 0) begin : g_ext_signed
            assign w_ext = WIDTH_ACC'($signed(bus.s_data));
        end else begin : g_ext_unsigned
            assign w_ext = WIDTH_ACC'(bus.s_data);
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = c_st_idle;
        end else if (w_accept) begin
            w_state_next = w_last ? c_st_idle : c_st_accum;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs / handshake
    // The completing sample is the only one that must wait for room in
    // the output register; partial sums keep flowing while a result is
    // pending.
    // ------------------------------------------------------------------
    always_comb begin
        w_last = 1'b0;
        if (r_state == c_st_idle) begin
            w_last = (len <= c_len_one);
        end else begin
            w_last = (r_cnt == (r_len_q - c_len_one));
        end
        w_s_ready  = !clear && (!r_m_valid || bus.m_ready || !w_last);
        w_accept   = bus.s_valid && w_s_ready;
        w_complete = w_accept && w_last;
    end

    // ------------------------------------------------------------------
    // Adder. r_acc (and the sticky flag) are always zero in IDLE, so the
    // first sample of a block needs no separate load path.
    // ------------------------------------------------------------------
`ifdef INTDUMP_SAT_EN
    logic [WIDTH_ACC:0]   w_sum_wide;
    logic                 w_add_ovf;
    logic [WIDTH_ACC-1:0] w_sat_val;
    logic                 w_ovf_next;
    logic                 r_ovf;
    logic                 r_m_ovf;

    generate
        if (IS_SIGNED != 0) begin : g_sat_signed
            assign w_sum_wide = (WIDTH_ACC+1)'($signed(r_acc)) + (WIDTH_ACC+1)'($signed(w_ext));
            // Extra top bit is the true sign; disagreement with the
            // WIDTH_ACC sign bit means the sum left the representable range.
            assign w_add_ovf  = w_sum_wide[WIDTH_ACC] ^ w_sum_wide[WIDTH_ACC-1];
            assign w_sat_val  = w_sum_wide[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                                      : {1'b0, {(WIDTH_ACC-1){1'b1}}};
        end else begin : g_sat_unsigned
            assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_ext};
            assign w_add_ovf  = w_sum_wide[WIDTH_ACC];
            assign w_sat_val  = '1;
        end
    endgenerate

    // Once saturated, the accumulator is pinned for the rest of the block.
    assign w_acc_next = r_ovf ? r_acc : (w_add_ovf ? w_sat_val : w_sum_wide[WIDTH_ACC-1:0]);
    assign w_ovf_next = r_ovf | w_add_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_last ? 1'b0 : w_ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_ovf <= 1'b0;
        end else if (w_complete) begin
            r_m_ovf <= w_ovf_next;
        end
    end

    assign bus.m_ovf = r_m_ovf;
`else
    assign w_acc_next = r_acc + w_ext;
    assign bus.m_ovf  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accumulator, sample counter and latched block length
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == c_st_idle) begin
                r_len_q <= w_len_eff;
            end
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + c_len_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: a completing block reloads even while the previous
    // result is being consumed, giving back-to-back results.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_complete) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_acc_next;
        end else if (r_m_valid && bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_integrate_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_integrate_dump
//  Description : Self-checking bench for integrate_dump. A block-level model
//                (queue of accepted samples, plain integer sum) tracks the
//                signed DUT every cycle; directed sequences pin the model with
//                literal results; a second DUT instance covers unsigned mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_integrate_dump;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear;
    logic [3:0] len;
    logic       clear_u;
    logic [3:0] len_u;

    integrate_dump_if #(.WIDTH_IN(16), .WIDTH_ACC(19)) bus ();
    integrate_dump_if #(.WIDTH_IN(16), .WIDTH_ACC(19)) bus_u ();

    integrate_dump #(.WIDTH_IN(16), .WIDTH_ACC(19), .LEN_WIDTH(4), .IS_SIGNED(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .len   (len),
        .bus   (bus)
    );

    integrate_dump #(.WIDTH_IN(16), .WIDTH_ACC(19), .LEN_WIDTH(4), .IS_SIGNED(0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_u),
        .len   (len_u),
        .bus   (bus_u)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Block-level reference model for the signed instance
    // ------------------------------------------------------------------
    longint      mdl_blk[$];
    int          mdl_len   = 0;
    bit          mdl_valid = 1'b0;
    logic [18:0] mdl_data  = '0;
    bit          mdl_ovf   = 1'b0;

    function automatic int eff_len(input logic [3:0] l);
        return (l == 4'd0) ? 1 : int'(l);
    endfunction

    function automatic void mdl_finish();
        longint s = 0;
        bit     o = 1'b0;
        foreach (mdl_blk[i]) begin
`ifdef INTDUMP_SAT_EN
            if (!o) begin
                s += mdl_blk[i];
                if (s > 262143) begin
                    s = 262143;
                    o = 1'b1;
                end else if (s < -262144) begin
                    s = -262144;
                    o = 1'b1;
                end
            end
`else
            s += mdl_blk[i];
`endif
        end
        mdl_data = s[18:0];
        mdl_ovf  = o;
    endfunction

    always @(negedge clk) begin : p_cmp
        bit last;
        bit exp_ready;
        bit take;
        if (!rst_n) begin
            mdl_blk.delete();
            mdl_len   = 0;
            mdl_valid = 1'b0;
            mdl_data  = '0;
            mdl_ovf   = 1'b0;
        end else begin
            last      = (mdl_blk.size() == 0) ? (eff_len(len) == 1) : (mdl_blk.size() == mdl_len - 1);
            exp_ready = !clear && (!mdl_valid || bus.m_ready || !last);
            chk("s_ready", longint'(bus.s_ready), longint'(exp_ready));
            chk("m_valid", longint'(bus.m_valid), longint'(mdl_valid));
            if (mdl_valid) begin
                chk("m_data", longint'(bus.m_data), longint'(mdl_data));
                chk("m_ovf", longint'(bus.m_ovf), longint'(mdl_ovf));
            end
            take = bus.s_valid && exp_ready;
            if (mdl_valid && bus.m_ready) mdl_valid = 1'b0;
            if (clear) begin
                mdl_blk.delete();
            end else if (take) begin
                if (mdl_blk.size() == 0) mdl_len = eff_len(len);
                mdl_blk.push_back(longint'($signed(bus.s_data)));
                if (mdl_blk.size() == mdl_len) begin
                    mdl_finish();
                    mdl_valid = 1'b1;
                    mdl_blk.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [15:0] d, output int stalls);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!ok) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            if (!ok) begin
                stalls++;
                if (stalls > 40) begin
                    chk("send_timeout", longint'(stalls), 0);
                    ok = 1'b1;
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int st;
        int total;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b1;
        clear         = 1'b0;
        len           = 4'd4;
        bus_u.s_valid = 1'b0;
        bus_u.s_data  = '0;
        bus_u.m_ready = 1'b1;
        clear_u       = 1'b0;
        len_u         = 4'd0;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_s_ready", longint'(bus.s_ready), 1);
        chk("rst_m_valid", longint'(bus.m_valid), 0);
        chk("rst_m_data", longint'(bus.m_data), 0);
        chk("rst_m_ovf", longint'(bus.m_ovf), 0);

        // Basic sum followed by a back-to-back block
        len   = 4'd4;
        total = 0;
        send(16'd1, st); total += st;
        send(16'd2, st); total += st;
        send(16'd3, st); total += st;
        chk("basic_no_early", longint'(bus.m_valid), 0);
        send(16'd4, st); total += st;
        chk("basic_valid", longint'(bus.m_valid), 1);
        chk("basic_sum", longint'($signed(bus.m_data)), 10);
        chk("basic_ovf", longint'(bus.m_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            send(16'd5, st);
            total += st;
        end
        chk("b2b_sum", longint'($signed(bus.m_data)), 20);
        chk("b2b_no_stall", longint'(total), 0);

        // Signed extremes
        len = 4'd8;
        for (int i = 0; i < 8; i++) send(16'h8000, st);
        chk("neg_full_sum", longint'($signed(bus.m_data)), -262144);
        chk("neg_full_ovf", longint'(bus.m_ovf), 0);
        len = 4'd15;
        for (int i = 0; i < 15; i++) send(16'h7FFF, st);
`ifdef INTDUMP_SAT_EN
        chk("pos_sat_sum", longint'($signed(bus.m_data)), 262143);
        chk("pos_sat_ovf", longint'(bus.m_ovf), 1);
`else
        chk("pos_wrap_sum", longint'($signed(bus.m_data)), -32783);
        chk("pos_wrap_ovf", longint'(bus.m_ovf), 0);
`endif
        tick();

        // Backpressure
        len         = 4'd2;
        bus.m_ready = 1'b0;
        send(16'd1, st);
        send(16'd1, st);
        chk("bp_valid", longint'(bus.m_valid), 1);
        chk("bp_first", longint'($signed(bus.m_data)), 2);
        send(16'd5, st);
        chk("bp_partial_no_stall", longint'(st), 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", longint'(bus.s_ready), 0);
            chk("bp_hold_data", longint'($signed(bus.m_data)), 2);
        end
        tick();
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", longint'(bus.s_ready), 1);
        tick();
        bus.s_valid = 1'b0;
        chk("bp_second_valid", longint'(bus.m_valid), 1);
        chk("bp_second", longint'($signed(bus.m_data)), 11);
        tick();

        // Abort with clear
        len = 4'd4;
        send(16'd7, st);
        send(16'd7, st);
        clear       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd7;
        @(negedge clk);
        chk("abort_ready", longint'(bus.s_ready), 0);
        tick();
        clear       = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_no_out", longint'(bus.m_valid), 0);
        for (int i = 0; i < 4; i++) send(16'd1, st);
        chk("abort_next", longint'($signed(bus.m_data)), 4);

        // Asynchronous reset mid-block
        tick();
        send(16'd3, st);
        send(16'd3, st);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", longint'(bus.m_valid), 0);
        chk("arst_m_data", longint'(bus.m_data), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(16'd3, st);
        chk("arst_next", longint'($signed(bus.m_data)), 12);

        // Unsigned instance, len = 0 acts as 1
        tick();
        bus_u.s_valid = 1'b1;
        bus_u.s_data  = 16'hFFFF;
        @(negedge clk);
        chk("u_ready0", longint'(bus_u.s_ready), 1);
        tick();
        chk("u_valid0", longint'(bus_u.m_valid), 1);
        chk("u_data0", longint'(bus_u.m_data), 65535);
        bus_u.s_data = 16'd1;
        @(negedge clk);
        chk("u_ready1", longint'(bus_u.s_ready), 1);
        tick();
        chk("u_valid1", longint'(bus_u.m_valid), 1);
        chk("u_data1", longint'(bus_u.m_data), 1);
        bus_u.s_valid = 1'b0;
        tick();
        chk("u_drain", longint'(bus_u.m_valid), 0);

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 800; i++) begin
            tick();
            bus.s_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       bus.s_data = 16'h7FFF;
                1:       bus.s_data = 16'h8000;
                default: bus.s_data = 16'($urandom);
            endcase
            bus.m_ready = ($urandom_range(0, 9) < 6);
            clear       = ($urandom_range(0, 29) == 0);
            len         = 4'($urandom_range(0, 15));
        end
        tick();
        bus.s_valid = 1'b0;
        clear       = 1'b0;
        bus.m_ready = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
